// File: rtl/core2axi4l_pipe.sv
// core2axi4l_pipe: bridge from an Ibex-style req/gnt/rvalid port to an AXI4-Lite master.
// Up to MAX_OUTSTANDING same-type transactions may be in flight, and responses come
// back in issue order. Reads and writes are never mixed while any transaction is
// outstanding, so that order holds without a reorder buffer.
// Optional feature: define CORE2AXI4L_RESP_REG_EN to register the core response
// (core_rvalid_o/core_rdata_o/core_err_o). This adds one cycle after the AXI handshake.
// Without it the response passes straight through.
module core2axi4l_pipe #(
    parameter int          AW              = 32,
    parameter int          DW              = 32,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [2:0]  PROT            = 3'b000
) (
    input  logic              clk,
    input  logic              rst,
    // core side
    input  logic              core_req_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    input  logic              core_we_i,
    input  logic [DW/8-1:0]   core_be_i,
    input  logic [AW-1:0]     core_addr_i,
    input  logic [DW-1:0]     core_wdata_i,
    output logic [DW-1:0]     core_rdata_o,
    output logic              core_err_o,
    // AXI4-Lite write address
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [AW-1:0]     awaddr_o,
    output logic [2:0]        awprot_o,
    // AXI4-Lite write data
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DW-1:0]     wdata_o,
    output logic [DW/8-1:0]   wstrb_o,
    // AXI4-Lite write response
    input  logic              bvalid_i,
    output logic              bready_o,
    input  logic [1:0]        bresp_i,
    // AXI4-Lite read address
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [AW-1:0]     araddr_o,
    output logic [2:0]        arprot_o,
    // AXI4-Lite read data
    input  logic              rvalid_i,
    output logic              rready_o,
    input  logic [DW-1:0]     rdata_i,
    input  logic [1:0]        rresp_i
);

    localparam int SW      = DW / 8;
    localparam int ADDR_LSB = $clog2(SW);
    localparam int CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] ONE     = CW'(1);
    // clears the byte-offset bits so AXI always sees a bus-aligned address
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'((1 << ADDR_LSB) - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_ADDR = 2'd1,
        WR      = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           mode_q, mode_d;      // 1 = write, 0 = read
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [SW-1:0]  be_q, be_d;
    logic           aw_done_q, aw_done_d;
    logic           w_done_q, w_done_d;

    logic           aw_fire, w_fire;
    logic           b_hs, r_hs;
    logic           resp_valid;
    logic [DW-1:0]  resp_data;
    logic           resp_err;
    logic           cnt_dec;

    // Only xRESP[1] (SLVERR/DECERR) matters to the core
    logic unused_resp_lsb;
    assign unused_resp_lsb = ^{bresp_i[0], rresp_i[0]};

    // AXI request channels are driven straight from registered state, so they
    // stay stable until the handshake completes
    assign arvalid_o = (state_q == RD_ADDR);
    assign araddr_o  = addr_q;
    assign arprot_o  = PROT;
    assign awvalid_o = (state_q == WR) && !aw_done_q;
    assign awaddr_o  = addr_q;
    assign awprot_o  = PROT;
    assign wvalid_o  = (state_q == WR) && !w_done_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = be_q;

    assign aw_fire = awvalid_o && awready_i;
    assign w_fire  = wvalid_o && wready_i;

    // Only the channel matching the current mode is ready, and only while
    // something is outstanding
    assign bready_o = (cnt_q != '0) && mode_q;
    assign rready_o = (cnt_q != '0) && !mode_q;
    assign b_hs     = bvalid_i && bready_o;
    assign r_hs     = rvalid_i && rready_o;

    assign resp_valid = b_hs || r_hs;
    assign resp_data  = r_hs ? rdata_i : '0;
    assign resp_err   = r_hs ? rresp_i[1] : (b_hs && bresp_i[1]);

`ifdef CORE2AXI4L_RESP_REG_EN
    logic           rvalid_q;
    logic [DW-1:0]  rdata_q;
    logic           err_q;

    // Register the response one cycle after the AXI handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= resp_valid;
            rdata_q  <= resp_data;
            err_q    <= resp_err;
        end
    end

    assign core_rvalid_o = rvalid_q;
    assign core_rdata_o  = rdata_q;
    assign core_err_o    = err_q;
    assign cnt_dec       = rvalid_q;
`else
    assign core_rvalid_o = resp_valid;
    assign core_rdata_o  = resp_data;
    assign core_err_o    = resp_err;
    assign cnt_dec       = resp_valid;
`endif

    // Next-state logic: accept, issue on AXI, grant the core
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        core_gnt_o = 1'b0;
        case (state_q)
            IDLE: begin
                // A request of the other type waits for the pipe to drain
                if (core_req_i && (cnt_q < MAX_CNT) &&
                    ((cnt_q == '0) || (core_we_i == mode_q))) begin
                    addr_d    = core_addr_i & ALIGN_MASK;
                    wdata_d   = core_wdata_i;
                    be_d      = core_be_i;
                    mode_d    = core_we_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = core_we_i ? WR : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (arready_i) begin
                    core_gnt_o = 1'b1;
                    state_d    = IDLE;
                end
            end
            WR: begin
                aw_done_d = aw_done_q || aw_fire;
                w_done_d  = w_done_q || w_fire;
                // grant when the later of the two handshakes lands
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    core_gnt_o = 1'b1;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outstanding counter: grants add, responses retire, both together cancel
    always_comb begin
        cnt_d = cnt_q;
        if (core_gnt_o && !cnt_dec) begin
            cnt_d = cnt_q + ONE;
        end else if (!core_gnt_o && cnt_dec) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // State registers; reset drops anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule

// File: tb/tb_core2axi4l_pipe.sv
// Bench for core2axi4l_pipe: reactive AXI4-Lite slave plus an in-order response scoreboard.
module tb_core2axi4l_pipe;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXO = 2;
`ifdef CORE2AXI4L_RESP_REG_EN
    localparam int RESP_LAT = 1;
`else
    localparam int RESP_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic            core_req, core_gnt, core_rvalid, core_we, core_err;
    logic [SW-1:0]   core_be;
    logic [AW-1:0]   core_addr;
    logic [DW-1:0]   core_wdata, core_rdata;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic [DW-1:0]   wdata, rdata;
    logic [SW-1:0]   wstrb;
    logic [1:0]      bresp, rresp;

    core2axi4l_pipe #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(MAXO), .PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .core_req_i(core_req), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .core_we_i(core_we), .core_be_i(core_be), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_rdata_o(core_rdata), .core_err_o(core_err),
        .awvalid_o(awvalid), .awready_i(awready), .awaddr_o(awaddr), .awprot_o(awprot),
        .wvalid_o(wvalid), .wready_i(wready), .wdata_o(wdata), .wstrb_o(wstrb),
        .bvalid_i(bvalid), .bready_o(bready), .bresp_i(bresp),
        .arvalid_o(arvalid), .arready_i(arready), .araddr_o(araddr), .arprot_o(arprot),
        .rvalid_i(rvalid), .rready_o(rready), .rdata_i(rdata), .rresp_i(rresp)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard: {err, rdata} expected per issued request, in order
    logic [DW:0] sb_q[$];

    // slave model
    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    resp;
        int            t;
    } rsp_t;
    rsp_t rq[$];
    rsp_t bq[$];
    int            ar_delay = 0, aw_delay = 0, w_delay = 0, resp_delay = 0;
    bit            hold = 1'b0;
    logic [DW-1:0] rd_data_k = '0;
    logic [1:0]    rd_resp_k = 2'b00, b_resp_k = 2'b00;
    int            ar_wait = 0, aw_wait = 0, w_wait = 0;

    // sampled events (at negedge)
    int  cyc = 0;
    bit  ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s, hs_prev;
    bit  wr_aw_ok, wr_w_ok;
    int  ar_hs_cyc, aw_hs_cyc, w_hs_cyc, gnt_cyc;
    int  gnt_cnt = 0, rv_cnt = 0;
    logic [SW-1:0] w_hs_strb;
    bit  ar_pend, aw_pend, w_pend;
    logic [AW-1:0] ar_addr_p, aw_addr_p;
    logic [DW-1:0] w_data_p;
    logic [SW-1:0] w_strb_p;

    // Monitor: sample handshakes, check AXI stability, response timing and scoreboard
    always @(negedge clk) begin
        bit hs_now, exp_rv;
        logic [DW:0] e;
        cyc++;
        if (rst) begin
            ar_hs_s = 0; aw_hs_s = 0; w_hs_s = 0; r_hs_s = 0; b_hs_s = 0;
            hs_prev = 0; wr_aw_ok = 0; wr_w_ok = 0;
            ar_pend = 0; aw_pend = 0; w_pend = 0;
            gnt_cnt = 0; rv_cnt = 0;
        end else begin
            if (ar_pend) begin
                check_eq("ar_valid_held", arvalid, 1);
                check_eq("ar_addr_stable", araddr, ar_addr_p);
            end
            if (aw_pend) begin
                check_eq("aw_valid_held", awvalid, 1);
                check_eq("aw_addr_stable", awaddr, aw_addr_p);
            end
            if (w_pend) begin
                check_eq("w_valid_held", wvalid, 1);
                check_eq("w_data_stable", {wstrb, wdata}, {w_strb_p, w_data_p});
            end
            ar_pend = arvalid && !arready; ar_addr_p = araddr;
            aw_pend = awvalid && !awready; aw_addr_p = awaddr;
            w_pend  = wvalid && !wready;   w_data_p = wdata; w_strb_p = wstrb;

            ar_hs_s = arvalid && arready;
            aw_hs_s = awvalid && awready;
            w_hs_s  = wvalid && wready;
            r_hs_s  = rvalid && rready;
            b_hs_s  = bvalid && bready;
            if (ar_hs_s) begin
                ar_hs_cyc = cyc;
                rq.push_back('{d: rd_data_k, resp: rd_resp_k, t: cyc + resp_delay});
            end
            if (aw_hs_s) begin aw_hs_cyc = cyc; wr_aw_ok = 1; end
            if (w_hs_s) begin w_hs_cyc = cyc; w_hs_strb = wstrb; wr_w_ok = 1; end
            if (wr_aw_ok && wr_w_ok) begin
                bq.push_back('{d: '0, resp: b_resp_k, t: cyc + resp_delay});
                wr_aw_ok = 0; wr_w_ok = 0;
            end

            hs_now = r_hs_s || b_hs_s;
            exp_rv = (RESP_LAT != 0) ? hs_prev : hs_now;
            if (core_rvalid || exp_rv) check_eq("rvalid_timing", core_rvalid, exp_rv);
            hs_prev = hs_now;

            if (core_rvalid) begin
                rv_cnt++;
                check_eq("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    $display("resp: rdata=%08h err=%0d (exp %08h/%0d)", core_rdata, core_err, e[DW-1:0], e[DW]);
                    check_eq("resp_rdata", core_rdata, e[DW-1:0]);
                    check_eq("resp_err", core_err, e[DW]);
                end
            end
            if (core_gnt) begin
                gnt_cyc = cyc;
                gnt_cnt++;
                check_eq("outstanding_max", (gnt_cnt - rv_cnt) <= MAXO, 1);
            end
        end
    end

    // Slave driver: updates ready/valid just after each rising edge
    always @(posedge clk) begin
        #1;
        if (rst) begin
            arready = 0; awready = 0; wready = 0;
            rvalid = 0; bvalid = 0;
            ar_wait = 0; aw_wait = 0; w_wait = 0;
            rq.delete(); bq.delete();
        end else begin
            if (ar_hs_s) begin ar_wait = 0; arready = 0; end
            else if (arvalid) begin ar_wait++; arready = (ar_wait > ar_delay); end
            else arready = 0;
            if (aw_hs_s) begin aw_wait = 0; awready = 0; end
            else if (awvalid) begin aw_wait++; awready = (aw_wait > aw_delay); end
            else awready = 0;
            if (w_hs_s) begin w_wait = 0; wready = 0; end
            else if (wvalid) begin w_wait++; wready = (w_wait > w_delay); end
            else wready = 0;

            if (r_hs_s) begin rvalid = 0; void'(rq.pop_front()); end
            if (!rvalid && rq.size() != 0 && !hold && cyc >= rq[0].t) begin
                rvalid = 1; rdata = rq[0].d; rresp = rq[0].resp;
            end
            if (!rvalid) begin rdata = 32'hBAD0BAD0; rresp = 2'b11; end

            if (b_hs_s) begin bvalid = 0; void'(bq.pop_front()); end
            if (!bvalid && bq.size() != 0 && !hold && cyc >= bq[0].t) begin
                bvalid = 1; bresp = bq[0].resp;
            end
            if (!bvalid) bresp = 2'b11;
        end
    end

    // Issue one core request (entered and left just after a rising edge)
    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [SW-1:0] be,
                         input logic [DW-1:0] wd, input logic [DW-1:0] exp_d, input bit exp_e);
        bit got;
        core_req = 1; core_we = we; core_addr = addr; core_be = be; core_wdata = wd;
        sb_q.push_back({exp_e, exp_d});
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (arvalid) check_eq("araddr_aligned", araddr, addr & ~32'h3);
            if (awvalid) check_eq("awaddr_aligned", awaddr, addr & ~32'h3);
            if (wvalid)  check_eq("w_strb_data", {wstrb, wdata}, {be, wd});
            if (core_gnt) got = 1;
        end
        check_eq("gnt_seen", got, 1);
        $display("issue: we=%0d addr=%08h be=%b wdata=%08h gnt=%0d", we, addr, be, wd, got);
        @(posedge clk); #1;
        core_req = 0; core_addr = '1; core_be = '0; core_wdata = '1; core_we = ~we;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
        check_eq("drain", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit saw_ar;
        rst = 1; core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rdata = 0; rresp = 0; bresp = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
        check_eq("rst_readies", {bready, rready}, 2'b00);
        check_eq("rst_core", {core_gnt, core_rvalid, core_err}, 3'b000);
        @(posedge clk); #1; rst = 0;
        @(posedge clk); #1;

        // 1: single read, response 2 cycles after the ar handshake
        resp_delay = 2; rd_data_k = 32'hDEADBEEF; rd_resp_k = 2'b00;
        issue(0, 32'h0000_1003, 4'hF, 32'h0, 32'hDEADBEEF, 0);
        drain();
        check_eq("t1_gnt_in_ar_cycle", gnt_cyc, ar_hs_cyc);

        // 2: write, wready immediate, awready after 3 cycles
        resp_delay = 0; aw_delay = 3; w_delay = 0; b_resp_k = 2'b00;
        issue(1, 32'h0000_2006, 4'b0011, 32'h1234_5678, 32'h0, 0);
        drain();
        check_eq("t2_w_before_aw", w_hs_cyc < aw_hs_cyc, 1);
        check_eq("t2_gnt_in_aw_cycle", gnt_cyc, aw_hs_cyc);
        check_eq("t2_wstrb", w_hs_strb, 4'b0011);
        aw_delay = 0;

        // 3: three back-to-back reads with responses withheld
        hold = 1;
        fork
            begin
                rd_data_k = 32'hA0A0_0001; issue(0, 32'h100, 4'hF, 0, 32'hA0A0_0001, 0);
                rd_data_k = 32'hA0A0_0002; issue(0, 32'h104, 4'hF, 0, 32'hA0A0_0002, 0);
                rd_data_k = 32'hA0A0_0003; issue(0, 32'h108, 4'hF, 0, 32'hA0A0_0003, 0);
            end
            begin
                int g0;
                g0 = gnt_cnt;
                repeat (12) @(negedge clk);
                check_eq("t3_two_gnts", gnt_cnt - g0, 2);
                check_eq("t3_ar_blocked", arvalid, 0);
                hold = 0;
            end
        join
        drain();

        // 4: read outstanding, then a write must wait for the read response
        hold = 1; rd_data_k = 32'h5555_AAAA;
        issue(0, 32'h200, 4'hF, 0, 32'h5555_AAAA, 0);
        fork
            issue(1, 32'h204, 4'b1100, 32'hCAFE_F00D, 32'h0, 0);
            begin
                repeat (6) @(negedge clk);
                check_eq("t4_no_aw_w", {awvalid, wvalid}, 2'b00);
                hold = 0;
            end
        join
        drain();

        // 5: error responses
        b_resp_k = 2'b10;
        issue(1, 32'h300, 4'hF, 32'h0BAD_0BAD, 32'h0, 1);
        drain();
        b_resp_k = 2'b00; rd_resp_k = 2'b11; rd_data_k = 32'h0000_E44E;
        issue(0, 32'h304, 4'hF, 0, 32'h0000_E44E, 1);
        drain();
        rd_resp_k = 2'b01; rd_data_k = 32'h0000_0E0E;
        issue(0, 32'h308, 4'hF, 0, 32'h0000_0E0E, 0);
        drain();
        rd_resp_k = 2'b00;

        // 6: reset while arvalid is high with one read outstanding
        hold = 1; rd_data_k = 32'h6666_6666;
        issue(0, 32'h400, 4'hF, 0, 32'h6666_6666, 0);
        ar_delay = 50;
        core_req = 1; core_we = 0; core_addr = 32'h404; core_be = 4'hF;
        saw_ar = 0;
        for (int i = 0; i < 10 && !saw_ar; i++) begin
            @(negedge clk);
            if (arvalid) saw_ar = 1;
        end
        check_eq("t6_arvalid_up", saw_ar, 1);
        #1 rst = 1;
        #1;
        check_eq("t6_arvalid_async_clr", arvalid, 0);
        check_eq("t6_readies_clr", {bready, rready}, 2'b00);
        check_eq("t6_no_core_resp", {core_rvalid, core_gnt}, 2'b00);
        core_req = 0;
        sb_q.delete();
        @(posedge clk); #1; @(posedge clk); #1;
        hold = 0; ar_delay = 0;
        rst = 0;
        repeat (4) @(posedge clk); #1;
        check_eq("t6_no_stale_resp", rv_cnt, 0);

        // recovery read after reset
        rd_data_k = 32'h7777_0001;
        issue(0, 32'h500, 4'hF, 0, 32'h7777_0001, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
